// File: rtl/vga_timing_pkg.sv
// Shared types and default 640x480@60 raster timing for the VGA timing generator.
package vga_timing_pkg;

  typedef logic [15:0] coord_t;

  localparam int unsigned HTotalDef   = 800;
  localparam int unsigned HSyncDef    = 96;
  localparam int unsigned HActBegDef  = 144;
  localparam int unsigned HActEndDef  = 784;
  localparam int unsigned VTotalDef   = 525;
  localparam int unsigned VSyncDef    = 2;
  localparam int unsigned VActBegDef  = 35;
  localparam int unsigned VActEndDef  = 515;
  localparam int unsigned SyncDlyDef  = 3;

  localparam logic SyncActive = 1'b0;
  localparam logic SyncIdle   = 1'b1;

  function automatic logic in_span(coord_t x, coord_t lo, coord_t hi);
    return (x >= lo) && (x < hi);
  endfunction

endpackage

// File: rtl/vga_sync_delay.sv
// Pixel-enable gated shift register that lines the sync/blank outputs up with registered RGB.
module vga_sync_delay #(
  parameter int unsigned      Width    = 3,
  parameter int unsigned      Depth    = 3,
  parameter logic [Width-1:0] ResetVal = '0
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             ce_i,
  input  logic [Width-1:0] data_i,
  output logic [Width-1:0] data_o
);

  if (Depth == 0) begin : g_bypass
    logic unused_ctrl;
    assign unused_ctrl = ^{clk_i, rst_ni, ce_i};
    assign data_o = data_i;
  end else begin : g_shift
    logic [Width-1:0] stage_q [Depth];

    always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
        for (int unsigned i = 0; i < Depth; i++) stage_q[i] <= ResetVal;
      end else if (ce_i) begin
        stage_q[0] <= data_i;
        for (int unsigned i = 1; i < Depth; i++) stage_q[i] <= stage_q[i-1];
      end
    end

    assign data_o = stage_q[Depth-1];
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator: counters, active window, line/frame pulses, delayed syncs.
// Define VTG_FRAME_CNT_EN to add the 16-bit frame_count output.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_TOTAL   = HTotalDef,
  parameter int unsigned H_SYNC    = HSyncDef,
  parameter int unsigned H_ACT_BEG = HActBegDef,
  parameter int unsigned H_ACT_END = HActEndDef,
  parameter int unsigned V_TOTAL   = VTotalDef,
  parameter int unsigned V_SYNC    = VSyncDef,
  parameter int unsigned V_ACT_BEG = VActBegDef,
  parameter int unsigned V_ACT_END = VActEndDef,
  parameter int unsigned SYNC_DLY  = SyncDlyDef
) (
  input  logic        clkin,
  input  logic        reset_n,
  input  logic        pix_ce,
  output logic [15:0] hValue,
  output logic [15:0] vValue,
  output logic        activeVideo,
  output logic        line_start,
  output logic        frame_start,
  output logic        VGA_HS,
  output logic        VGA_VS,
  output logic        VGA_BLANK_N,
  output logic        VGA_SYNC_N
`ifdef VTG_FRAME_CNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  coord_t h_q, h_d, v_q, v_d;
  logic   act_q, act_d, hs_q, hs_d, vs_q, vs_d;
  logic   ls_q, ls_d, fs_q, fs_d;
  logic   h_wrap, v_wrap;
  logic [2:0] sync_dly;

  // Window and sync flags are derived from the next counts so they align with hValue/vValue.
  always_comb begin
    h_wrap = (h_q == coord_t'(H_TOTAL - 1));
    v_wrap = (v_q == coord_t'(V_TOTAL - 1));
    h_d    = h_q;
    v_d    = v_q;
    act_d  = act_q;
    hs_d   = hs_q;
    vs_d   = vs_q;
    if (pix_ce) begin
      h_d = h_wrap ? '0 : h_q + 16'd1;
      if (h_wrap) v_d = v_wrap ? '0 : v_q + 16'd1;
      act_d = in_span(h_d, coord_t'(H_ACT_BEG), coord_t'(H_ACT_END)) &&
              in_span(v_d, coord_t'(V_ACT_BEG), coord_t'(V_ACT_END));
      hs_d  = (h_d < coord_t'(H_SYNC)) ? SyncActive : SyncIdle;
      vs_d  = (v_d < coord_t'(V_SYNC)) ? SyncActive : SyncIdle;
    end
    ls_d = pix_ce & h_wrap;
    fs_d = pix_ce & h_wrap & v_wrap;
  end

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) begin
      h_q   <= '0;
      v_q   <= '0;
      act_q <= 1'b0;
      hs_q  <= SyncIdle;
      vs_q  <= SyncIdle;
      ls_q  <= 1'b0;
      fs_q  <= 1'b0;
    end else begin
      h_q   <= h_d;
      v_q   <= v_d;
      act_q <= act_d;
      hs_q  <= hs_d;
      vs_q  <= vs_d;
      ls_q  <= ls_d;
      fs_q  <= fs_d;
    end
  end

  vga_sync_delay #(
    .Width    (3),
    .Depth    (SYNC_DLY),
    .ResetVal ({SyncIdle, SyncIdle, 1'b0})
  ) u_sync_delay (
    .clk_i  (clkin),
    .rst_ni (reset_n),
    .ce_i   (pix_ce),
    .data_i ({hs_q, vs_q, act_q}),
    .data_o (sync_dly)
  );

  assign hValue      = h_q;
  assign vValue      = v_q;
  assign activeVideo = act_q;
  assign line_start  = ls_q;
  assign frame_start = fs_q;
  assign VGA_HS      = sync_dly[2];
  assign VGA_VS      = sync_dly[1];
  assign VGA_BLANK_N = sync_dly[0];
  assign VGA_SYNC_N  = 1'b0;

`ifdef VTG_FRAME_CNT_EN
  logic [15:0] frame_cnt_q;

  always_ff @(posedge clkin or negedge reset_n) begin
    if (!reset_n) frame_cnt_q <= '0;
    else if (fs_d) frame_cnt_q <= frame_cnt_q + 16'd1;
  end

  assign frame_count = frame_cnt_q;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: a shrunken-raster instance for whole-frame behaviour plus a default 640x480 one.
module tb_vga_timing_gen;

  logic clk = 1'b0;
  logic reset_n;
  logic pix_ce;

  always #5 clk = ~clk;

  logic [15:0] s_h, s_v, d_h, d_v;
  logic s_act, s_ls, s_fs, s_hs, s_vs, s_bl, s_sn;
  logic d_act, d_ls, d_fs, d_hs, d_vs, d_bl, d_sn;
`ifdef VTG_FRAME_CNT_EN
  logic [15:0] s_fc, d_fc;
`endif

  // 20x10 raster, 200 steps per frame, 12x5 active window
  vga_timing_gen #(
    .H_TOTAL(20), .H_SYNC(3), .H_ACT_BEG(5), .H_ACT_END(17),
    .V_TOTAL(10), .V_SYNC(2), .V_ACT_BEG(3), .V_ACT_END(8), .SYNC_DLY(3)
  ) dut_s (
    .clkin(clk), .reset_n(reset_n), .pix_ce(pix_ce),
    .hValue(s_h), .vValue(s_v), .activeVideo(s_act),
    .line_start(s_ls), .frame_start(s_fs),
    .VGA_HS(s_hs), .VGA_VS(s_vs), .VGA_BLANK_N(s_bl), .VGA_SYNC_N(s_sn)
`ifdef VTG_FRAME_CNT_EN
    , .frame_count(s_fc)
`endif
  );

  vga_timing_gen dut_d (
    .clkin(clk), .reset_n(reset_n), .pix_ce(pix_ce),
    .hValue(d_h), .vValue(d_v), .activeVideo(d_act),
    .line_start(d_ls), .frame_start(d_fs),
    .VGA_HS(d_hs), .VGA_VS(d_vs), .VGA_BLANK_N(d_bl), .VGA_SYNC_N(d_sn)
`ifdef VTG_FRAME_CNT_EN
    , .frame_count(d_fc)
`endif
  );

  int unsigned n_pass  = 0;
  int unsigned n_total = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  function automatic logic [37:0] snap_s();
    return {s_h, s_v, s_act, s_ls, s_fs, s_hs, s_vs, s_bl};
  endfunction

  // Holds reset for 10 clocks, optionally checks idle state, releases just after an edge.
  task automatic do_reset(input bit chk);
    reset_n = 1'b0;
    pix_ce  = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    if (chk) begin
      check("reset_small", 64'(snap_s()), 64'({16'd0, 16'd0, 6'b000110}));
      check("reset_default", 64'({d_h, d_v, d_act, d_ls, d_fs, d_hs, d_vs, d_bl}),
            64'({16'd0, 16'd0, 6'b000110}));
      check("sync_n", 64'({s_sn, d_sn}), 64'(2'b00));
`ifdef VTG_FRAME_CNT_EN
      check("reset_frame_count", 64'(s_fc), 64'd0);
`endif
    end
    reset_n = 1'b1;
  endtask

  // flags = {activeVideo, line_start, frame_start, VGA_HS, VGA_VS, VGA_BLANK_N}
  typedef struct {
    int         adv;
    int         h;
    int         v;
    logic [5:0] flags;
  } vec_t;

  vec_t vecs [12];

  initial begin
    int first_act, last_act, act_cnt, fs1, fs2, low_cnt, fall_at, max_h, bad, fs_cnt;
    logic prev_hs, ce_used;
    logic [15:0] prev_h;

    vecs[0]  = '{1,  1,  0, 6'b000110};
    vecs[1]  = '{3,  4,  0, 6'b000000};
    vecs[2]  = '{15, 19, 0, 6'b000100};
    vecs[3]  = '{1,  0,  1, 6'b010100};
    vecs[4]  = '{3,  3,  1, 6'b000000};
    vecs[5]  = '{42, 5,  3, 6'b100010};
    vecs[6]  = '{3,  8,  3, 6'b100111};
    vecs[7]  = '{88, 16, 7, 6'b100111};
    vecs[8]  = '{1,  17, 7, 6'b000111};
    vecs[9]  = '{42, 19, 9, 6'b000110};
    vecs[10] = '{1,  0,  0, 6'b011110};
    vecs[11] = '{3,  3,  0, 6'b000000};

    reset_n = 1'b0;
    pix_ce  = 1'b1;
    do_reset(1'b1);

    for (int i = 0; i < 12; i++) begin
      step(vecs[i].adv);
      check($sformatf("vec%0d", i), 64'(snap_s()),
            64'({16'(vecs[i].h), 16'(vecs[i].v), vecs[i].flags}));
    end

    // Default timing: one line wrap, hsync width and delay on the second line.
    do_reset(1'b0);
    low_cnt = 0; fall_at = -1; max_h = 0; prev_hs = 1'b1;
    for (int p = 1; p <= 1600; p++) begin
      step(1);
      if (int'(d_h) > max_h) max_h = int'(d_h);
      if (p == 800) check("default_wrap", 64'({d_h, d_v, d_ls}), 64'({16'd0, 16'd1, 1'b1}));
      if (p >= 801) begin
        if (!d_hs) low_cnt++;
        if (prev_hs && !d_hs && fall_at < 0) fall_at = p;
      end
      prev_hs = d_hs;
    end
    check("default_max_h", 64'(max_h), 64'd799);
    check("default_hs_width", 64'(low_cnt), 64'd96);
    check("default_hs_fall", 64'(fall_at), 64'd803);

    // Small raster: two frames, active window extent and frame period.
    do_reset(1'b0);
    first_act = -1; last_act = -1; act_cnt = 0; fs1 = -1; fs2 = -1;
    for (int p = 1; p <= 400; p++) begin
      step(1);
      if (p <= 200 && s_act) begin
        act_cnt++;
        if (first_act < 0) first_act = p;
        last_act = p;
      end
      if (s_fs) begin
        if (fs1 < 0) fs1 = p;
        else if (fs2 < 0) fs2 = p;
      end
    end
    check("active_count", 64'(act_cnt), 64'd60);
    check("first_active", 64'(first_act), 64'd65);
    check("last_active", 64'(last_act), 64'd156);
    check("first_frame_start", 64'(fs1), 64'd200);
    check("second_frame_start", 64'(fs2), 64'd400);
`ifdef VTG_FRAME_CNT_EN
    step(200);
    check("frame_count_3", 64'(s_fc), 64'd3);
`endif

    // pix_ce toggling: everything holds on disabled clocks, frame takes twice as long.
    do_reset(1'b0);
    bad = 0; fs1 = -1; fs2 = -1;
    for (int c = 1; c <= 1200; c++) begin
      pix_ce  = (c % 2 == 1);
      ce_used = pix_ce;
      prev_h  = s_h;
      step(1);
      if (!ce_used && (s_ls || s_fs || s_h != prev_h)) bad++;
      if (s_fs) begin
        if (fs1 < 0) fs1 = c;
        else if (fs2 < 0) fs2 = c;
      end
    end
    pix_ce = 1'b1;
    check("ce_hold_violations", 64'(bad), 64'd0);
    check("ce_first_frame_start", 64'(fs1), 64'd399);
    check("ce_frame_period", 64'(fs2 - fs1), 64'd400);

    // Reset mid-frame restarts at (0,0) with no early frame_start.
    do_reset(1'b0);
    step(132);
    check("mid_position", 64'({s_h, s_v}), 64'({16'd12, 16'd6}));
    #2 reset_n = 1'b0;
    #1 check("async_reset", 64'({s_h, s_v, s_ls, s_fs}), 64'd0);
    repeat (3) @(posedge clk);
    #1 reset_n = 1'b1;
    fs_cnt = 0;
    for (int p = 1; p < 200; p++) begin
      step(1);
      if (s_fs) fs_cnt++;
    end
    check("no_spurious_frame_start", 64'(fs_cnt), 64'd0);
    step(1);
    check("restart_frame_start", 64'({s_h, s_v, s_fs}), 64'({16'd0, 16'd0, 1'b1}));

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
